// File: rtl/note_envelope_pwm.sv
// note_envelope_pwm: ADSR-style envelope gating a square-wave tone through a 4-bit PWM.
module note_envelope_pwm #(
  parameter int SILENCE_TICKS = 512,
  parameter int STEP_DIV = 64,
  parameter int ATTACK_INC = 4,
  parameter int SUSTAIN_LEVEL = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tone_in,
  input  logic       ena,
  output logic       audio_out,
  output logic       audio_out_n,
  output logic [3:0] env_level,
  output logic       note_active
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  state_t state, state_nxt;
  logic       tone_in_d;
  logic [9:0] sil_cnt;
  logic [7:0] presc;
  logic [3:0] pwm_cnt, level_nxt, level_dn;
  logic [4:0] level_up;
  logic       onset, silent, strobe, release_go;
  assign onset = tone_in & ~tone_in_d;
  assign silent = sil_cnt == 10'(SILENCE_TICKS);
  assign strobe = presc == 8'(STEP_DIV - 1);
  assign level_up = {1'b0, env_level} + 5'(ATTACK_INC);
  assign level_dn = env_level == 4'd0 ? 4'd0 : env_level - 4'd1;
  // the tone is a square wave, so onsets recur while a note plays; they only
  // matter in IDLE/RELEASE, but still veto a coincident silence release
  assign release_go = silent & ~onset;
  assign note_active = state != IDLE;
  assign audio_out_n = ~audio_out;
  always_comb begin
    state_nxt = state;
    level_nxt = env_level;
    case (state)
      IDLE: begin
        level_nxt = 4'd0;
        if (onset) state_nxt = ATTACK;
      end
      ATTACK:
        if (release_go) state_nxt = RELEASE;
        else if (strobe) begin
          level_nxt = level_up >= 5'd15 ? 4'd15 : level_up[3:0];
          if (level_up >= 5'd15) state_nxt = DECAY;
        end
      DECAY:
        if (release_go) state_nxt = RELEASE;
        else if (strobe) begin
          level_nxt = level_dn;
          if (level_dn == 4'(SUSTAIN_LEVEL)) state_nxt = SUSTAIN;
        end
      SUSTAIN:
        if (release_go) state_nxt = RELEASE;
      RELEASE:
        if (onset) state_nxt = ATTACK;
        else if (strobe) begin
          level_nxt = level_dn;
          if (level_dn == 4'd0) state_nxt = IDLE;
        end
      default: begin
        state_nxt = IDLE;
        level_nxt = 4'd0;
      end
    endcase
    if (!ena) begin
      state_nxt = IDLE;
      level_nxt = 4'd0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      env_level <= 4'd0;
      presc     <= 8'd0;
      pwm_cnt   <= 4'd0;
      sil_cnt   <= 10'd0;
      tone_in_d <= 1'b0;
      audio_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      env_level <= level_nxt;
      tone_in_d <= tone_in;
      pwm_cnt   <= pwm_cnt + 4'd1;
      sil_cnt   <= tone_in ? 10'd0 : silent ? sil_cnt : sil_cnt + 10'd1;
      presc     <= ((state_nxt == ATTACK) && (state != ATTACK)) || strobe ? 8'd0 : presc + 8'd1;
      audio_out <= ena ? tone_in & (pwm_cnt < env_level) : tone_in;
    end
endmodule

// File: tb/tb_note_envelope_pwm.sv
// tb_note_envelope_pwm: directed checks of envelope timing, release, retrigger, PWM, bypass and reset.
module tb_note_envelope_pwm;
  logic clk = 1'b0, reset_n = 1'b0, tone_in = 1'b0, tone2 = 1'b0, ena = 1'b1;
  logic audio_out, audio_out_n, note_active, audio2, audio2_n, note2;
  logic [3:0] env_level, level2;
  int checks = 0, failures = 0;

  note_envelope_pwm dut (
    .clk(clk), .reset_n(reset_n), .tone_in(tone_in), .ena(ena),
    .audio_out(audio_out), .audio_out_n(audio_out_n), .env_level(env_level), .note_active(note_active)
  );

  note_envelope_pwm #(.SILENCE_TICKS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .tone_in(tone2), .ena(ena),
    .audio_out(audio2), .audio_out_n(audio2_n), .env_level(level2), .note_active(note2)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if (env_level !== 4'd0 || note_active !== 1'b0 || audio_out !== 1'b0 || audio_out_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: level=%0d active=%b out=%b out_n=%b, want 0 0 0 1",
               env_level, note_active, audio_out, audio_out_n);
    end
    reset_n = 1'b1;
    tick(2);
    checks++;
    if (note_active !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: active=%b want 0", note_active);
    end
  endtask

  // onset followed by a held tone; the onset edge is cycle 0
  task automatic note_to_sustain(input string tag);
    int at[8] = '{63, 64, 127, 128, 192, 256, 703, 704};
    logic [3:0] want[8] = '{4'd0, 4'd4, 4'd4, 4'd8, 4'd12, 4'd15, 4'd9, 4'd8};
    int now = 0;
    tone_in = 1'b1;
    tick(1);
    checks++;
    if (note_active !== 1'b1) begin
      failures++;
      $display("FAIL %s_onset: active=%b want 1", tag, note_active);
    end
    for (int i = 0; i < 8; i++) begin
      tick(at[i] - now);
      now = at[i];
      checks++;
      if (env_level !== want[i]) begin
        failures++;
        $display("FAIL %s_level_c%0d: level=%0d want %0d", tag, at[i], env_level, want[i]);
      end
    end
    tick(200);
    checks++;
    if (env_level !== 4'd8 || note_active !== 1'b1) begin
      failures++;
      $display("FAIL %s_sustain: level=%0d active=%b want 8 1", tag, env_level, note_active);
    end
  endtask

  task automatic test_attack_decay;
    note_to_sustain("ad");
  endtask

  // tone drops at cycle 904: silent at 1416, RELEASE at 1417, strobes at multiples of 64
  task automatic test_release;
    tone_in = 1'b0;
    tick(567);
    checks++;
    if (env_level !== 4'd8) begin
      failures++;
      $display("FAIL rel_hold: level=%0d want 8", env_level);
    end
    tick(1);
    checks++;
    if (env_level !== 4'd7) begin
      failures++;
      $display("FAIL rel_first_step: level=%0d want 7", env_level);
    end
    tick(447);
    checks++;
    if (env_level !== 4'd1 || note_active !== 1'b1) begin
      failures++;
      $display("FAIL rel_last_step: level=%0d active=%b want 1 1", env_level, note_active);
    end
    tick(1);
    checks++;
    if (env_level !== 4'd0 || note_active !== 1'b0) begin
      failures++;
      $display("FAIL rel_to_idle: level=%0d active=%b want 0 0", env_level, note_active);
    end
  endtask

  task automatic test_retrigger;
    note_to_sustain("rt");
    tone_in = 1'b0;
    tick(706);
    checks++;
    if (env_level !== 4'd5) begin
      failures++;
      $display("FAIL rt_release_level: level=%0d want 5", env_level);
    end
    tone_in = 1'b1;
    tick(1);
    checks++;
    if (env_level !== 4'd5 || note_active !== 1'b1) begin
      failures++;
      $display("FAIL rt_retain: level=%0d active=%b want 5 1", env_level, note_active);
    end
    tick(63);
    checks++;
    if (env_level !== 4'd5) begin
      failures++;
      $display("FAIL rt_presc_cleared: level=%0d want 5", env_level);
    end
    tick(1);
    checks++;
    if (env_level !== 4'd9) begin
      failures++;
      $display("FAIL rt_step1: level=%0d want 9", env_level);
    end
    tick(64);
    checks++;
    if (env_level !== 4'd13) begin
      failures++;
      $display("FAIL rt_step2: level=%0d want 13", env_level);
    end
    tick(64);
    checks++;
    if (env_level !== 4'd15) begin
      failures++;
      $display("FAIL rt_step3: level=%0d want 15", env_level);
    end
  endtask

  task automatic test_pwm;
    int highs = 0, bad_n = 0;
    tick(500);
    checks++;
    if (env_level !== 4'd8) begin
      failures++;
      $display("FAIL pwm_level: level=%0d want 8", env_level);
    end
    for (int i = 0; i < 32; i++) begin
      tick(1);
      highs += int'(audio_out);
      bad_n += int'(audio_out_n !== ~audio_out);
    end
    checks++;
    if (highs != 16) begin
      failures++;
      $display("FAIL pwm_duty: high=%0d of 32 want 16", highs);
    end
    checks++;
    if (bad_n != 0) begin
      failures++;
      $display("FAIL pwm_complement: bad=%0d want 0", bad_n);
    end
  endtask

  task automatic test_bypass;
    logic [7:0] pat = 8'b1011_0010;
    ena = 1'b0;
    tick(1);
    checks++;
    if (env_level !== 4'd0 || note_active !== 1'b0) begin
      failures++;
      $display("FAIL byp_forced_idle: level=%0d active=%b want 0 0", env_level, note_active);
    end
    for (int i = 0; i < 8; i++) begin
      tone_in = pat[i];
      tick(1);
      checks++;
      if (audio_out !== pat[i]) begin
        failures++;
        $display("FAIL byp_follow_%0d: out=%b want %b", i, audio_out, pat[i]);
      end
    end
    tone_in = 1'b1;
    tick(1);
    ena = 1'b1;
    tick(5);
    checks++;
    if (note_active !== 1'b0) begin
      failures++;
      $display("FAIL ena_no_onset: active=%b want 0", note_active);
    end
  endtask

  // SILENCE_TICKS=2: two low cycles saturate the counter just as the tone returns
  task automatic test_simultaneous;
    tone2 = 1'b1;
    tick(1);
    tick(64);
    checks++;
    if (level2 !== 4'd4) begin
      failures++;
      $display("FAIL sim_attack: level=%0d want 4", level2);
    end
    tone2 = 1'b0;
    tick(2);
    tone2 = 1'b1;
    tick(1);
    checks++;
    if (level2 !== 4'd4 || note2 !== 1'b1) begin
      failures++;
      $display("FAIL sim_coincide: level=%0d active=%b want 4 1", level2, note2);
    end
    tick(61);
    checks++;
    if (level2 !== 4'd8) begin
      failures++;
      $display("FAIL sim_attack_wins: level=%0d want 8", level2);
    end
  endtask

  task automatic test_reset_mid_attack;
    int pulses = 0;
    tone_in = 1'b0;
    tick(2);
    tone_in = 1'b1;
    tick(71);
    checks++;
    if (env_level !== 4'd4) begin
      failures++;
      $display("FAIL mid_attack_level: level=%0d want 4", env_level);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (env_level !== 4'd0 || note_active !== 1'b0 || audio_out !== 1'b0 || audio_out_n !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: level=%0d active=%b out=%b out_n=%b want 0 0 0 1",
               env_level, note_active, audio_out, audio_out_n);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pulses += int'(audio_out);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_silent: pulses=%0d want 0", pulses);
    end
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (note_active !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_onset: active=%b want 1", note_active);
    end
    tick(63);
    checks++;
    if (env_level !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_c63: level=%0d want 0", env_level);
    end
    tick(1);
    checks++;
    if (env_level !== 4'd4) begin
      failures++;
      $display("FAIL post_reset_c64: level=%0d want 4", env_level);
    end
  endtask

  initial begin
    test_reset;
    test_attack_decay;
    test_release;
    test_retrigger;
    test_pwm;
    test_bypass;
    test_simultaneous;
    test_reset_mid_attack;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_envelope_pwm.md
NOTE_ENVELOPE_PWM -- requirements
Module: note_envelope_pwm

Interface
REQ-001 Parameter SILENCE_TICKS, default 512: consecutive low tone_in cycles that mark a note's end (legal range 2..1023).
REQ-002 Parameter STEP_DIV, default 64: clock cycles per envelope step (legal range 2..255).
REQ-003 Parameter ATTACK_INC, default 4: level increment per attack step (legal range 1..15).
REQ-004 Parameter SUSTAIN_LEVEL, default 8: sustain level (legal range 1..14).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 tone_in  input  1  square-wave tone from the player stage, synchronous to clk.
REQ-008 ena  input  1  1 = envelope active; 0 = bypass.
REQ-009 audio_out  output  1  registered, envelope-shaped speaker drive.
REQ-010 audio_out_n  output  1  complement of audio_out.
REQ-011 env_level  output  4  current envelope level, 0..15.
REQ-012 note_active  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 tone_in_d SHALL be tone_in registered once; onset = tone_in & ~tone_in_d.
REQ-014 Silence counter (10-bit) SHALL clear on tone_in=1, else increment, saturating at SILENCE_TICKS; silent = (counter == SILENCE_TICKS).
REQ-015 Step prescaler SHALL count 0..STEP_DIV-1 and wrap; step strobe = (prescaler == STEP_DIV-1); prescaler clears on any ATTACK entry.
REQ-016 FSM states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-017 IDLE: env_level held at 0; onset -> ATTACK.
REQ-018 ATTACK: on strobe, level = min(level+ATTACK_INC, 15); if the result is 15 -> DECAY in the same cycle.
REQ-019 DECAY: on strobe, level-1; if the result equals SUSTAIN_LEVEL -> SUSTAIN in the same cycle.
REQ-020 SUSTAIN: level held.
REQ-021 ATTACK, DECAY or SUSTAIN with silent=1 -> RELEASE; level is unchanged in that transition cycle.
REQ-022 RELEASE: on strobe, level-1; if the result is 0 -> IDLE.
REQ-023 Onset in RELEASE -> ATTACK, retaining the current level (retrigger).
REQ-024 If onset and silent assert in the same cycle, onset SHALL take precedence.
REQ-025 Level arithmetic SHALL never wrap below 0 or above 15.
REQ-026 PWM counter (4-bit) SHALL be free-running with wrap 15->0.
REQ-027 With ena=1, audio_out SHALL register tone_in & (pwm_cnt < env_level), giving 1-cycle latency and a duty of env_level/16.
REQ-028 With ena=0, audio_out SHALL register tone_in directly.
REQ-029 With ena=0, the FSM and env_level SHALL be forced to IDLE/0; the prescaler and silence counter keep running.
REQ-030 ena rising SHALL NOT by itself create an onset; only a tone_in rising edge does.

Reset
REQ-031 reset_n=0 SHALL immediately clear all of the following: FSM to IDLE; env_level, prescaler, PWM counter, silence counter, tone_in_d, audio_out to 0; audio_out_n to 1.
REQ-032 Reset asserted mid-note SHALL abort the note with no further audio_out pulses.
REQ-033 The first onset after reset release SHALL start a normal ATTACK.

Verification
REQ-034 Reset: assert reset_n=0 asynchronously mid-ATTACK -> the same instant gives env_level=0, note_active=0, audio_out=0, audio_out_n=1.
REQ-035 Attack/decay: ena=1, tone_in 0->1 and held -> env_level is 4, 8, 12, 15 at cycles 64, 128, 192, 256 after the onset, then decrements to 8 by cycle 704, then SUSTAIN.
REQ-036 Release: in SUSTAIN (level 8), drive tone_in=0 -> RELEASE 512 cycles later; level 0 and IDLE 8 strobes after that; note_active falls.
REQ-037 Retrigger: tone_in rises in RELEASE at level 5 -> ATTACK with prescaler cleared; levels 9, 13, 15 on the next three strobes.
REQ-038 PWM: tone_in=1 in SUSTAIN at level 8 -> audio_out high in exactly 8 of every 16 cycles; with ena=0 it follows tone_in with 1-cycle delay.
REQ-039 Simultaneous events: onset coincident with silent saturation, using SILENCE_TICKS=2 -> ATTACK wins.
